// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory/IO stage: device register map,
// access FSM state encoding and read/write encoding.
package lc3_pkg;

  localparam logic [15:0] DEF_KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] DEF_KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DEF_DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DEF_DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mem_state_t;

  typedef enum logic {
    RW_READ  = 1'b0,
    RW_WRITE = 1'b1
  } rw_t;

endpackage

// File: rtl/lc3_mem_ctrl_if.sv
// External synchronous RAM port. The controller drives the strobe, address
// and write data; the RAM returns read data a fixed latency later.
interface lc3_mem_ctrl_if;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport master (output mem_en, output mem_we, output mem_addr,
                  output mem_wdata, input mem_rdata);
  modport slave  (input mem_en, input mem_we, input mem_addr,
                  input mem_wdata, output mem_rdata);
endinterface

// File: rtl/lc3_io_regs.sv
// Keyboard and display device registers (KBSR/KBDR/DSR/DDR), their
// handshakes, and the device read mux. Register side effects happen on the
// edge where the access FSM enters DONE (acc high).
module lc3_io_regs #(
  parameter logic [15:0] KBSR_ADDR = lc3_pkg::DEF_KBSR_ADDR,
  parameter logic [15:0] KBDR_ADDR = lc3_pkg::DEF_KBDR_ADDR,
  parameter logic [15:0] DSR_ADDR  = lc3_pkg::DEF_DSR_ADDR,
  parameter logic [15:0] DDR_ADDR  = lc3_pkg::DEF_DDR_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        acc,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic        wdata_ie,
  input  logic [7:0]  wdata_ch,
  output logic        is_dev,
  output logic [15:0] rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready
);

  logic       kb_rdy_r;
  logic       kb_ie_r;
  logic [7:0] kbdr_r;
  logic       dsr_rdy_r;
  logic       dd_valid_r;
  logic [7:0] dd_data_r;

  logic kbdr_rd_s;
  logic kbsr_wr_s;
  logic ddr_wr_s;

  // Address decode and read mux over the current (pre-edge) register values.
  always_comb begin
    is_dev = 1'b0;
    rdata  = 16'h0000;
    case (addr)
      KBSR_ADDR: begin is_dev = 1'b1; rdata = {kb_rdy_r, kb_ie_r, 14'b0}; end
      KBDR_ADDR: begin is_dev = 1'b1; rdata = {8'h00, kbdr_r}; end
      DSR_ADDR:  begin is_dev = 1'b1; rdata = {dsr_rdy_r, 15'b0}; end
      DDR_ADDR:  begin is_dev = 1'b1; rdata = {8'h00, dd_data_r}; end
      default:   begin is_dev = 1'b0; rdata = 16'h0000; end
    endcase
  end

  // Per-register access strobes for the DONE-entry cycle.
  always_comb begin
    kbdr_rd_s = acc && !wr && (addr == KBDR_ADDR);
    kbsr_wr_s = acc &&  wr && (addr == KBSR_ADDR);
    ddr_wr_s  = acc &&  wr && (addr == DDR_ADDR);
  end

  // Keyboard registers: a new key sets ready and beats a coincident KBDR read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      kb_rdy_r <= 1'b0;
      kb_ie_r  <= 1'b0;
      kbdr_r   <= 8'h00;
    end else begin
      if (kbdr_rd_s) kb_rdy_r <= 1'b0;
      if (kbsr_wr_s) kb_ie_r  <= wdata_ie;
      if (kb_valid) begin
        kbdr_r   <= kb_data;
        kb_rdy_r <= 1'b1;
      end
    end
  end

  // Display registers: a DDR write overrides a same-cycle handshake completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      dsr_rdy_r  <= 1'b1;
      dd_valid_r <= 1'b0;
      dd_data_r  <= 8'h00;
    end else begin
      if (dd_valid_r && dd_ready) begin
        dd_valid_r <= 1'b0;
        dsr_rdy_r  <= 1'b1;
      end
      if (ddr_wr_s) begin
        dd_data_r  <= wdata_ch;
        dd_valid_r <= 1'b1;
        dsr_rdy_r  <= 1'b0;
      end
    end
  end

  assign dd_valid = dd_valid_r;
  assign dd_data  = dd_data_r;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO stage: holds MAR/MDR, runs one RAM or device access per
// mio_en request and reports completion on r.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int          MEM_LATENCY = 2,
  parameter logic [15:0] KBSR_ADDR   = DEF_KBSR_ADDR,
  parameter logic [15:0] KBDR_ADDR   = DEF_KBDR_ADDR,
  parameter logic [15:0] DSR_ADDR    = DEF_DSR_ADDR,
  parameter logic [15:0] DDR_ADDR    = DEF_DDR_ADDR
) (
  input  logic        i_Clk,
  input  logic        reset,
  input  logic [15:0] bus,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        rw,
  output logic        r,
  output logic [15:0] mar_q,
  output logic [15:0] mdr_q,
  lc3_mem_ctrl_if.master ram,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ready
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_LATENCY - 1);

  mem_state_t  state_r, state_nx_s;
  logic [7:0]  cnt_r;
  logic [15:0] mar_r, mdr_r, rd_buf_r;
  logic        r_r, mem_en_r, mem_we_r;
  logic        dev_acc_s, ram_cap_s, is_dev_s;
  logic [15:0] dev_rdata_s;

  lc3_io_regs #(
    .KBSR_ADDR(KBSR_ADDR), .KBDR_ADDR(KBDR_ADDR),
    .DSR_ADDR (DSR_ADDR),  .DDR_ADDR (DDR_ADDR)
  ) u_io (
    .clk     (i_Clk),
    .reset   (reset),
    .acc     (dev_acc_s),
    .wr      (rw),
    .addr    (mar_r),
    .wdata_ie(mdr_r[14]),
    .wdata_ch(mdr_r[7:0]),
    .is_dev  (is_dev_s),
    .rdata   (dev_rdata_s),
    .kb_valid(kb_valid),
    .kb_data (kb_data),
    .dd_valid(dd_valid),
    .dd_data (dd_data),
    .dd_ready(dd_ready)
  );

  // Access FSM next state; dropping mio_en before DONE abandons the access.
  always_comb begin
    state_nx_s = state_r;
    dev_acc_s  = 1'b0;
    ram_cap_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mio_en && is_dev_s) begin
          state_nx_s = ST_DONE;
          dev_acc_s  = 1'b1;
        end else if (mio_en) begin
          state_nx_s = ST_ISSUE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!mio_en) begin
          state_nx_s = ST_IDLE;
        end else if (rw_t'(rw) == RW_WRITE) begin
          state_nx_s = ST_DONE;
        end else if (MEM_LATENCY == 1) begin
          state_nx_s = ST_DONE;
          ram_cap_s  = 1'b1;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mio_en) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == WAIT_LAST) begin
          state_nx_s = ST_DONE;
          ram_cap_s  = 1'b1;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (!mio_en) state_nx_s = ST_IDLE;
        else         state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register with registered r / RAM strobe derived from the next state.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      r_r      <= 1'b0;
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      r_r      <= (state_nx_s == ST_DONE);
      mem_en_r <= (state_nx_s == ST_ISSUE);
      mem_we_r <= (state_nx_s == ST_ISSUE) && (rw_t'(rw) == RW_WRITE);
    end
  end

  // WAIT cycle counter: 1 on the first WAIT cycle, last at MEM_LATENCY-1.
  always_ff @(posedge i_Clk) begin
    if (reset)                    cnt_r <= 8'd0;
    else if (state_r == ST_ISSUE) cnt_r <= 8'd1;
    else if (state_r == ST_WAIT)  cnt_r <= cnt_r + 8'd1;
  end

  // Read buffer: RAM data on the last WAIT edge, device data on DONE entry.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      rd_buf_r <= 16'h0000;
    end else if (ram_cap_s) begin
      rd_buf_r <= ram.mem_rdata;
    end else if (dev_acc_s && (rw_t'(rw) == RW_READ)) begin
      rd_buf_r <= dev_rdata_s;
    end
  end

  // MAR/MDR loads are honoured in every state.
  always_ff @(posedge i_Clk) begin
    if (reset) begin
      mar_r <= 16'h0000;
      mdr_r <= 16'h0000;
    end else begin
      if (ld_mar) mar_r <= bus;
      if (ld_mdr) mdr_r <= mio_en ? rd_buf_r : bus;
    end
  end

  assign r             = r_r;
  assign mar_q         = mar_r;
  assign mdr_q         = mdr_r;
  assign ram.mem_en    = mem_en_r;
  assign ram.mem_we    = mem_we_r;
  assign ram.mem_addr  = mar_r;
  assign ram.mem_wdata = mdr_r;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: vector table, directed corner-case
// sequences, and randomized accesses against a transaction-level model.
module tb_lc3_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bus = 16'h0000;
  logic        ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, rw = 1'b0;
  logic        r;
  logic [15:0] mar_q, mdr_q;
  logic        kb_valid = 1'b0;
  logic [7:0]  kb_data = 8'h00;
  logic        dd_valid;
  logic [7:0]  dd_data;
  logic        dd_ready = 1'b0;

  lc3_mem_ctrl_if ram_if ();

  lc3_mem_ctrl #(.MEM_LATENCY(LAT)) dut (
    .i_Clk(clk), .reset(reset), .bus(bus), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .rw(rw), .r(r), .mar_q(mar_q), .mdr_q(mdr_q),
    .ram(ram_if), .kb_valid(kb_valid), .kb_data(kb_data),
    .dd_valid(dd_valid), .dd_data(dd_data), .dd_ready(dd_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Known power-up RAM contents of the environment
  function automatic logic [15:0] ram_init(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  function automatic bit is_dev(input logic [15:0] a);
    return (a == 16'hFE00) || (a == 16'hFE02) || (a == 16'hFE04) || (a == 16'hFE06);
  endfunction

  // Environment RAM: one registered read stage (data valid in the WAIT cycle)
  logic [15:0] ram_q [0:65535];
  bit          ram_w [0:65535];
  logic        ram_clr = 1'b1;
  int          en_cnt = 0;
  logic        last_we;
  logic [15:0] last_addr, last_wdata;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 65536; i++) ram_w[i] <= 1'b0;
    end else if (ram_if.mem_en) begin
      en_cnt     <= en_cnt + 1;
      last_we    <= ram_if.mem_we;
      last_addr  <= ram_if.mem_addr;
      last_wdata <= ram_if.mem_wdata;
      if (ram_if.mem_we) begin
        ram_q[ram_if.mem_addr] <= ram_if.mem_wdata;
        ram_w[ram_if.mem_addr] <= 1'b1;
      end else begin
        ram_if.mem_rdata <= ram_w[ram_if.mem_addr] ? ram_q[ram_if.mem_addr]
                                                   : ram_init(ram_if.mem_addr);
      end
    end
  end

  // Transaction-level model of memory and device state
  logic [15:0] model_mem [logic [15:0]];
  bit          m_kb_rdy, m_kb_ie, m_dsr, m_dd_valid;
  logic [7:0]  m_kbdr, m_dd_data;

  task automatic model_reset();
    m_kb_rdy = 1'b0; m_kb_ie = 1'b0; m_kbdr = 8'h00;
    m_dsr = 1'b1; m_dd_valid = 1'b0; m_dd_data = 8'h00;
  endtask

  task automatic model_access(input logic [15:0] a, input bit wr, input logic [15:0] d,
                              input bit kbp, input logic [7:0] kbv, output logic [15:0] exp);
    exp = 16'h0000;
    if (!is_dev(a)) begin
      if (wr) model_mem[a] = d;
      else    exp = model_mem.exists(a) ? model_mem[a] : ram_init(a);
    end else if (!wr) begin
      case (a)
        16'hFE00: exp = {m_kb_rdy, m_kb_ie, 14'b0};
        16'hFE02: begin exp = {8'h00, m_kbdr}; m_kb_rdy = 1'b0; end
        16'hFE04: exp = {m_dsr, 15'b0};
        default:  exp = {8'h00, m_dd_data};
      endcase
    end else begin
      if (a == 16'hFE00) m_kb_ie = d[14];
      if (a == 16'hFE06) begin m_dd_data = d[7:0]; m_dd_valid = 1'b1; m_dsr = 1'b0; end
    end
    if (kbp) begin m_kbdr = kbv; m_kb_rdy = 1'b1; end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] v);
    @(negedge clk); bus = v; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    @(negedge clk); bus = v; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0;
  endtask

  // Full handshake: load MAR/MDR, raise mio_en, check latency and RAM strobe,
  // pull the read buffer through MDR, then drop mio_en and check r falls.
  task automatic do_access(input logic [15:0] a, input bit wr, input logic [15:0] d,
                           input bit kbp, input logic [7:0] kbv, output logic [15:0] rd);
    int lat, en0, exp_lat;
    bit dev;
    dev = is_dev(a);
    exp_lat = dev ? 1 : (wr ? 2 : LAT + 1);
    load_mar(a);
    bus = d; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0;
    rw = wr; mio_en = 1'b1; en0 = en_cnt;
    if (kbp) begin kb_valid = 1'b1; kb_data = kbv; end
    lat = 0;
    do begin
      @(negedge clk); kb_valid = 1'b0; lat++;
    end while (r !== 1'b1 && lat < 40);
    chk("latency", 16'(lat), 16'(exp_lat));
    chk("mem_en_count", 16'(en_cnt - en0), dev ? 16'd0 : 16'd1);
    if (!dev) begin
      chk("mem_we", {15'b0, last_we}, {15'b0, wr});
      chk("mem_addr", last_addr, a);
      if (wr) chk("mem_wdata", last_wdata, d);
    end
    ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0;
    rd = mdr_q;
    chk("r_held", {15'b0, r}, 16'd1);
    mio_en = 1'b0;
    @(negedge clk);
    chk("r_drop", {15'b0, r}, 16'd0);
  endtask

  task automatic txn(input logic [15:0] a, input bit wr, input logic [15:0] d,
                     input bit kbp, input logic [7:0] kbv, input string nm);
    logic [15:0] rd, exp;
    do_access(a, wr, d, kbp, kbv, rd);
    model_access(a, wr, d, kbp, kbv, exp);
    if (!wr) chk(nm, rd, exp);
    chk("dd_valid", {15'b0, dd_valid}, {15'b0, m_dd_valid});
    chk("dd_data", {8'h00, dd_data}, {8'h00, m_dd_data});
  endtask

  task automatic kb_press(input logic [7:0] v);
    @(negedge clk); kb_valid = 1'b1; kb_data = v;
    @(negedge clk); kb_valid = 1'b0;
    m_kbdr = v; m_kb_rdy = 1'b1;
  endtask

  task automatic dd_pulse();
    @(negedge clk); dd_ready = 1'b1;
    @(negedge clk); dd_ready = 1'b0;
    if (m_dd_valid) begin m_dd_valid = 1'b0; m_dsr = 1'b1; end
    chk("dd_valid_after_ready", {15'b0, dd_valid}, {15'b0, m_dd_valid});
  endtask

  function automatic logic [15:0] pick_ram();
    logic [15:0] a;
    if ($urandom_range(0, 1) == 1) a = 16'h6000 + 16'($urandom_range(0, 15));
    else                          a = 16'($urandom);
    if (is_dev(a)) a = 16'h6000;
    return a;
  endfunction

  typedef struct {
    logic [15:0] addr;
    bit          wr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [15:0] rd, exp;
    vecs[0]  = '{16'h4000, 1'b1, 16'hBEEF, 16'h0000};
    vecs[1]  = '{16'h3000, 1'b0, 16'h0000, 16'h1234};
    vecs[2]  = '{16'h4000, 1'b0, 16'h0000, 16'hBEEF};
    vecs[3]  = '{16'hFE04, 1'b0, 16'h0000, 16'h8000};
    vecs[4]  = '{16'hFE00, 1'b0, 16'h0000, 16'h0000};
    vecs[5]  = '{16'hFE02, 1'b0, 16'h0000, 16'h0000};
    vecs[6]  = '{16'hFFFF, 1'b1, 16'h5A5A, 16'h0000};
    vecs[7]  = '{16'hFFFF, 1'b0, 16'h0000, 16'h5A5A};
    vecs[8]  = '{16'hFE01, 1'b0, 16'h0000, ram_init(16'hFE01)};
    vecs[9]  = '{16'h0000, 1'b0, 16'h0000, 16'hA5A5};
    vecs[10] = '{16'hFE04, 1'b1, 16'h1234, 16'h0000};
    vecs[11] = '{16'hFE04, 1'b0, 16'h0000, 16'h8000};
    vecs[12] = '{16'hFE00, 1'b1, 16'hFFFF, 16'h0000};
    vecs[13] = '{16'hFE00, 1'b0, 16'h0000, 16'h4000};
    vecs[14] = '{16'hFE00, 1'b1, 16'h0000, 16'h0000};
    vecs[15] = '{16'hFE00, 1'b0, 16'h0000, 16'h0000};
    model_reset();

    repeat (3) @(negedge clk);
    reset = 1'b0; ram_clr = 1'b0;
    @(negedge clk);
    chk("rst_mar", mar_q, 16'h0000);
    chk("rst_mdr", mdr_q, 16'h0000);
    chk("rst_r", {15'b0, r}, 16'd0);
    chk("rst_mem_en", {15'b0, ram_if.mem_en}, 16'd0);
    chk("rst_dd_valid", {15'b0, dd_valid}, 16'd0);

    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, 8'h00, rd);
      model_access(vecs[i].addr, vecs[i].wr, vecs[i].wdata, 1'b0, 8'h00, exp);
      if (!vecs[i].wr) chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Keyboard: key arrival, status, data, ready cleared by the data read
    kb_press(8'h41);
    txn(16'hFE00, 1'b0, 16'h0000, 1'b0, 8'h00, "kbsr_after_key");
    txn(16'hFE02, 1'b0, 16'h0000, 1'b0, 8'h00, "kbdr_read");
    txn(16'hFE00, 1'b0, 16'h0000, 1'b0, 8'h00, "kbsr_after_read");
    chk("kbsr_cleared_model", {15'b0, m_kb_rdy}, 16'd0);

    // Key arriving in the same cycle as a KBDR read: old data, ready set
    do_access(16'hFE02, 1'b0, 16'h0000, 1'b1, 8'h7A, rd);
    chk("kbdr_coincident_old", rd, 16'h0041);
    model_access(16'hFE02, 1'b0, 16'h0000, 1'b1, 8'h7A, exp);
    txn(16'hFE00, 1'b0, 16'h0000, 1'b0, 8'h00, "kbsr_set_wins");
    txn(16'hFE02, 1'b0, 16'h0000, 1'b0, 8'h00, "kbdr_new");

    // Display: DDR write, held back by dd_ready=0, released by dd_ready=1
    txn(16'hFE06, 1'b1, 16'h0058, 1'b0, 8'h00, "ddr_write");
    chk("dd_valid_set", {15'b0, dd_valid}, 16'd1);
    chk("dd_data_58", {8'h00, dd_data}, 16'h0058);
    txn(16'hFE04, 1'b0, 16'h0000, 1'b0, 8'h00, "dsr_busy");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dd_valid_hold", {15'b0, dd_valid}, 16'd1);
    end
    dd_pulse();
    txn(16'hFE04, 1'b0, 16'h0000, 1'b0, 8'h00, "dsr_ready");

    // Abort a RAM read during WAIT: single strobe, r never rises
    begin
      int en0;
      load_mar(16'h3000);
      rw = 1'b0; mio_en = 1'b1; en0 = en_cnt;
      repeat (2) @(negedge clk);
      mio_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_rd_r", {15'b0, r}, 16'd0);
      end
      chk("abort_rd_strobes", 16'(en_cnt - en0), 16'd1);
    end
    txn(16'hFE04, 1'b0, 16'h0000, 1'b0, 8'h00, "idle_after_abort");

    // Abort a RAM write in ISSUE: strobe already issued, write persists
    load_mar(16'h5000);
    load_mdr(16'h1111);
    rw = 1'b1; mio_en = 1'b1;
    @(negedge clk);
    mio_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("abort_wr_r", {15'b0, r}, 16'd0);
    end
    model_mem[16'h5000] = 16'h1111;
    txn(16'h5000, 1'b0, 16'h0000, 1'b0, 8'h00, "abort_wr_kept");

    // Reset while in DONE after a DDR write
    load_mar(16'hFE06);
    load_mdr(16'h0042);
    rw = 1'b1; mio_en = 1'b1;
    @(negedge clk);
    chk("done_before_reset", {15'b0, r}, 16'd1);
    reset = 1'b1; mio_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("reset_r", {15'b0, r}, 16'd0);
    chk("reset_dd_valid", {15'b0, dd_valid}, 16'd0);
    chk("reset_mar", mar_q, 16'h0000);
    chk("reset_mdr", mdr_q, 16'h0000);
    chk("reset_mem_en", {15'b0, ram_if.mem_en}, 16'd0);
    txn(16'hFE04, 1'b0, 16'h0000, 1'b0, 8'h00, "dsr_after_reset");

    // Randomized mix of RAM and device traffic
    for (int i = 0; i < 150; i++) begin
      logic [15:0] a;
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0: txn(pick_ram(), 1'b1, 16'($urandom), 1'b0, 8'h00, "rand_ram_wr");
        1: txn(pick_ram(), 1'b0, 16'h0000, 1'b0, 8'h00, "rand_ram_rd");
        2: kb_press(8'($urandom));
        3: begin
          a = 16'hFE00 + 16'(2 * $urandom_range(0, 2));
          txn(a, 1'b0, 16'h0000, 1'b0, 8'h00, "rand_dev_rd");
        end
        4: begin
          a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
          txn(a, 1'b1, 16'($urandom), 1'b0, 8'h00, "rand_dev_wr");
        end
        default: dd_pulse();
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
